uart_instr_fetch: RTL



---
 rtl/bitty_fetch_pkg.sv | 12 +
 rtl/fetch_timeout_ctr.sv | 19 +
 rtl/uart_instr_fetch.sv | 87 ++++++++
 3 files changed

// File: rtl/bitty_fetch_pkg.sv
// bitty_fetch_pkg: fetch FSM state encoding, fetch command byte and default timing limits
package bitty_fetch_pkg;
  typedef enum logic [2:0] {
    IDLE, SEND_CMD, WAIT_CMD, SEND_ADDR, WAIT_ADDR, RECV_HI, RECV_LO, DONE
  } state_t;
  localparam logic [7:0] CMD_FETCH = 8'h66;
  localparam int TIMEOUT_CYCLES_DEF = 1_000_000;
  localparam int MAX_RETRIES_DEF = 3;
  function automatic logic is_wait(state_t s);
    return s inside {WAIT_CMD, WAIT_ADDR, RECV_HI, RECV_LO};
  endfunction
endpackage

// File: rtl/fetch_timeout_ctr.sv
// fetch_timeout_ctr: clearable saturating cycle counter; o_expired while enabled at LIMIT-1 (clk, reset, i_clr, i_en -> o_expired)
module fetch_timeout_ctr #(
  parameter int LIMIT = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int W = LIMIT > 1 ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] MAX = W'(LIMIT - 1);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en && r_cnt != MAX) r_cnt <= r_cnt + 1'b1;
  assign o_expired = i_en && r_cnt == MAX;
endmodule

// File: rtl/uart_instr_fetch.sv
// uart_instr_fetch: sends fetch cmd + PC over UART TX, assembles 16-bit instruction from two RX bytes; timeout with bounded retry
// Ports: start/address/stop_for_rw from top FSM; tx_done/rx_done/rx_data from UART; tx_start_out/tx_data_out to UART;
//        instruction_out/done_out to bitty; busy, err_out status.
module uart_instr_fetch
  import bitty_fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int MAX_RETRIES = MAX_RETRIES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  address,
  input  logic        stop_for_rw,
  input  logic        tx_done,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  output logic        tx_start_out,
  output logic [7:0]  tx_data_out,
  output logic [15:0] instruction_out,
  output logic        done_out,
  output logic        busy,
  output logic        err_out
);
  localparam int RW = $clog2(MAX_RETRIES + 2);
  state_t r_state, w_next;
  logic [7:0] r_addr, r_hi, r_tx_last;
  logic [15:0] r_instr;
  logic [RW-1:0] r_retry;
  logic w_wait, w_expired, w_retry_inc;
  assign w_wait = is_wait(r_state);
  fetch_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_ctr (
    .clk(clk),
    .reset(reset),
    .i_clr(!w_wait || w_next != r_state),
    .i_en(w_wait),
    .o_expired(w_expired)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    tx_start_out = 1'b0;
    done_out = 1'b0;
    err_out = 1'b0;
    w_retry_inc = 1'b0;
    case (r_state)
      IDLE:      w_next = start && !stop_for_rw ? SEND_CMD : IDLE;
      SEND_CMD:  begin tx_start_out = 1'b1; w_next = WAIT_CMD; end
      WAIT_CMD:  w_next = tx_done ? SEND_ADDR : WAIT_CMD;
      SEND_ADDR: begin tx_start_out = 1'b1; w_next = WAIT_ADDR; end
      WAIT_ADDR: w_next = tx_done ? RECV_HI : WAIT_ADDR;
      RECV_HI:   w_next = rx_done ? RECV_LO : RECV_HI;
      RECV_LO:   w_next = rx_done ? DONE : RECV_LO;
      DONE:      begin done_out = 1'b1; w_next = IDLE; end
      default:   w_next = IDLE;
    endcase
    // a byte landing on the final cycle wins over the timeout
    if (w_expired && w_next == r_state) begin
      err_out = r_retry == RW'(MAX_RETRIES);
      w_retry_inc = !err_out;
      w_next = err_out ? IDLE : SEND_CMD;
    end
  end
  always_comb
    tx_data_out = r_state == SEND_CMD ? CMD_FETCH : r_state == SEND_ADDR ? r_addr : r_tx_last;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_addr <= '0;
      r_retry <= '0;
      r_hi <= '0;
      r_tx_last <= '0;
      r_instr <= '0;
    end else begin
      if (r_state == IDLE && w_next == SEND_CMD) begin
        r_addr <= address;
        r_retry <= '0;
      end
      if (w_retry_inc) r_retry <= r_retry + 1'b1;
      if (r_state == RECV_HI && rx_done) r_hi <= rx_data;
      if (r_state == RECV_LO && rx_done) r_instr <= {r_hi, rx_data};
      if (tx_start_out) r_tx_last <= tx_data_out;
    end
  assign instruction_out = r_instr;
  assign busy = r_state != IDLE;
endmodule
